// File: rtl/rc4_plaintext_checker_pkg.sv
`default_nettype none
// ============================================================================
// Package  : rc4_check_pkg
// Purpose  : Shared types and ASCII constants for the RC4 plaintext checker.
// Revision : 1.0 - initial release
// ============================================================================
package rc4_check_pkg;

  // Checker sequencing: one read request, a wait for the memory, one decision
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    EVAL  = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Runtime-selectable accepted character set
  typedef enum logic [1:0] {
    MODE_LOWER = 2'd0,  // lowercase letters and space
    MODE_PRINT = 2'd1,  // any printable ASCII
    MODE_ALNUM = 2'd2,  // letters, digits and space
    MODE_RSVD  = 2'd3   // reserved, behaves as MODE_LOWER
  } char_mode_e;

  localparam logic [7:0] SPACE    = 8'd32;
  localparam logic [7:0] LC_A     = 8'd97;
  localparam logic [7:0] LC_Z     = 8'd122;
  localparam logic [7:0] UC_A     = 8'd65;
  localparam logic [7:0] UC_Z     = 8'd90;
  localparam logic [7:0] DIG_0    = 8'd48;
  localparam logic [7:0] DIG_9    = 8'd57;
  localparam logic [7:0] PRINT_LO = 8'd32;
  localparam logic [7:0] PRINT_HI = 8'd126;

  // Inclusive range test on an ASCII byte
  function automatic logic in_range(input logic [7:0] b,
                                    input logic [7:0] lo,
                                    input logic [7:0] hi);
    return (b >= lo) && (b <= hi);
  endfunction

  // The reserved encoding folds onto the lowercase set
  function automatic char_mode_e map_mode(input logic [1:0] m);
    return (m == MODE_RSVD) ? MODE_LOWER : char_mode_e'(m);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rc4_plaintext_checker_char_classifier.sv
`default_nettype none
// ============================================================================
// Module   : char_classifier
// Purpose  : Combinational test of one byte against the selected character set.
// Revision : 1.0 - initial release
// ============================================================================
module char_classifier
  import rc4_check_pkg::*;
(
  input  logic [7:0] char_byte,
  input  logic [1:0] mode,
  output logic       valid
);

  // Select the accepted set; unknown/reserved modes use the lowercase set
  always_comb begin
    valid = 1'b0;
    case (mode)
      MODE_PRINT: valid = in_range(char_byte, PRINT_LO, PRINT_HI);
      MODE_ALNUM: valid = in_range(char_byte, LC_A, LC_Z)
                        | in_range(char_byte, UC_A, UC_Z)
                        | in_range(char_byte, DIG_0, DIG_9)
                        | (char_byte == SPACE);
      default:    valid = in_range(char_byte, LC_A, LC_Z)
                        | (char_byte == SPACE);
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/rc4_plaintext_checker.sv
`default_nettype none
// ============================================================================
// Module   : rc4_plaintext_checker
// Purpose  : Reads MSG_LEN decrypted bytes through the start/finish memory
//            handshake, stops at the first byte outside the selected set and
//            reports the verdict over a four-phase start/finish handshake.
// Revision : 1.0 - initial release
// ============================================================================
module rc4_plaintext_checker
  import rc4_check_pkg::*;
#(
  parameter int MSG_LEN = 32,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int IDX_W   = $clog2(MSG_LEN + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] D_data_in,
  output logic [ADDR_W-1:0] D_address,
  output logic [DATA_W-1:0] D_data_out,
  output logic              D_readWrite,
  output logic              D_start_readWrite_op,
  input  logic              D_finish_readWrite_op,
  input  logic [1:0]        char_mode,
  input  logic              start_check,
  output logic              finish_check,
  output logic              key_Valid,
  output logic [IDX_W-1:0]  fail_index
);

  state_e             state;
  state_e             state_next;
  logic [IDX_W-1:0]   index;
  char_mode_e         mode_q;
  logic [DATA_W-1:0]  data_q;
  logic               byte_ok;
  logic               last_byte;

  // The read address is the byte index itself; it only moves in EVAL,
  // so it is naturally held for the whole WAIT phase
  assign D_address   = ADDR_W'(index);
  assign D_data_out  = '0;
  assign D_readWrite = 1'b0;
  assign last_byte   = (index == IDX_W'(MSG_LEN - 1));

  char_classifier u_classifier (
    .char_byte (data_q),
    .mode      (mode_q),
    .valid     (byte_ok)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode and handshake outputs
  always_comb begin
    state_next           = state;
    D_start_readWrite_op = 1'b0;
    finish_check         = 1'b0;
    case (state)
      IDLE:  if (start_check) state_next = ISSUE;
      ISSUE: begin
        D_start_readWrite_op = 1'b1;
        state_next           = WAIT;
      end
      WAIT:  if (D_finish_readWrite_op) state_next = EVAL;
      EVAL:  state_next = (!byte_ok || last_byte) ? DONE : ISSUE;
      DONE: begin
        finish_check = 1'b1;
        // Waiting for start to drop keeps a held start from retriggering
        if (!start_check) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: mode latch, byte capture, index advance and verdict
  always_ff @(posedge clk) begin
    if (reset) begin
      index      <= '0;
      mode_q     <= MODE_LOWER;
      data_q     <= '0;
      key_Valid  <= 1'b0;
      fail_index <= '0;
    end else begin
      case (state)
        IDLE: if (start_check) begin
          mode_q <= map_mode(char_mode);
          index  <= '0;
        end
        WAIT: if (D_finish_readWrite_op) data_q <= D_data_in;
        EVAL: begin
          if (!byte_ok) begin
            key_Valid  <= 1'b0;
            fail_index <= index;
          end else if (last_byte) begin
            key_Valid  <= 1'b1;
            fail_index <= IDX_W'(MSG_LEN);
          end else begin
            index <= index + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rc4_plaintext_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_rc4_plaintext_checker
// Purpose  : Self-checking bench for rc4_plaintext_checker with a memory
//            responder and a behavioural character-set reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rc4_plaintext_checker;

  localparam int MSG_LEN = 32;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 8;
  localparam int IDX_W   = $clog2(MSG_LEN + 1);

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] d_data_in;
  logic [ADDR_W-1:0] d_address;
  logic [DATA_W-1:0] d_data_out;
  logic              d_rw;
  logic              d_start;
  logic              d_finish;
  logic [1:0]        char_mode;
  logic              start_check;
  logic              finish_check;
  logic              key_valid;
  logic [IDX_W-1:0]  fail_index;

  logic [7:0] mem [0:255];

  int n_checks = 0;
  int n_fail   = 0;

  // memory responder configuration (written only by the stimulus process)
  bit zero_wait  = 1'b1;
  int stall_mode = 0;    // 1: fixed 2 stall cycles, 2: random 1..3

  // monitor / responder state (written only by the negedge process)
  int         reads[$];
  int         dbl_pulse   = 0;
  int         addr_moves  = 0;
  int         stall_total = 0;
  bit         pending, prev_start, active;
  int         cnt;
  logic [7:0] paddr;

  // observations of the last run
  int obs_lat, obs_n, obs_proto, obs_stall;
  bit obs_to, obs_addr_ok;

  always #5 clk = ~clk;

  assign d_data_in = mem[d_address];

  rc4_plaintext_checker #(
    .MSG_LEN (MSG_LEN),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .IDX_W   (IDX_W)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .D_data_in             (d_data_in),
    .D_address             (d_address),
    .D_data_out            (d_data_out),
    .D_readWrite           (d_rw),
    .D_start_readWrite_op  (d_start),
    .D_finish_readWrite_op (d_finish),
    .char_mode             (char_mode),
    .start_check           (start_check),
    .finish_check          (finish_check),
    .key_Valid             (key_valid),
    .fail_index            (fail_index)
  );

  // Protocol monitor followed by the memory responder, both at the falling edge
  always @(negedge clk) begin
    if (reset) begin
      pending    = 1'b0;
      active     = 1'b0;
      prev_start = 1'b0;
    end else begin
      if (d_start) begin
        reads.push_back(int'(d_address));
        if (prev_start) dbl_pulse++;
        pending = 1'b1;
        paddr   = d_address;
      end else if (pending) begin
        if (d_address !== paddr) addr_moves++;
        if (d_finish) pending = 1'b0;
      end
      prev_start = d_start;
    end
    if (zero_wait) begin
      d_finish = 1'b1;
    end else if (reset) begin
      d_finish = 1'b0;
    end else if (d_start) begin
      cnt = (stall_mode == 2) ? int'($urandom_range(1, 3)) : 2;
      stall_total += cnt;
      active   = 1'b1;
      d_finish = 1'b0;
    end else if (d_finish) begin
      d_finish = 1'b0;
      active   = 1'b0;
    end else if (active) begin
      if (cnt == 0) d_finish = 1'b1;
      else          cnt--;
    end
  end

  // Character-set rules written directly from the accepted sets
  function automatic bit char_ok(input logic [7:0] b, input int mode);
    bit lower, upper, digit, space;
    lower = (b >= "a") && (b <= "z");
    upper = (b >= "A") && (b <= "Z");
    digit = (b >= "0") && (b <= "9");
    space = (b == " ");
    case (mode)
      1:       return (b >= 8'd32) && (b <= 8'd126);
      2:       return lower || upper || digit || space;
      default: return lower || space;
    endcase
  endfunction

  // Expected verdict and number of bytes read for the current memory image
  function automatic void model(input int mode, output bit kv, output int fi, output int k);
    kv = 1'b1;
    fi = MSG_LEN;
    k  = MSG_LEN;
    for (int i = 0; i < MSG_LEN; i++) begin
      if (!char_ok(mem[i], mode)) begin
        kv = 1'b0;
        fi = i;
        k  = i + 1;
        return;
      end
    end
  endfunction

  task automatic set_memory_timing(input bit zw, input int sm);
    @(posedge clk); #2;
    zero_wait  = zw;
    stall_mode = sm;
    @(posedge clk); #2;
  endtask

  // Raise start (unless already high) and capture one run up to finish_check
  task automatic run_capture(input bit already_started);
    int base_r, base_d, base_m, base_s, n;
    base_r = reads.size();
    base_d = dbl_pulse;
    base_m = addr_moves;
    base_s = stall_total;
    if (!already_started) begin
      @(posedge clk); #2;
      start_check = 1'b1;
    end
    n      = 0;
    obs_to = 1'b0;
    while (1) begin
      @(posedge clk); #1;
      n++;
      if (finish_check === 1'b1) break;
      if (n >= 3000) begin
        obs_to = 1'b1;
        break;
      end
    end
    obs_lat     = n - 1;
    obs_n       = reads.size() - base_r;
    obs_addr_ok = 1'b1;
    for (int i = 0; i < obs_n; i++)
      if (reads[base_r + i] != i) obs_addr_ok = 1'b0;
    obs_proto = (dbl_pulse - base_d) + (addr_moves - base_m);
    obs_stall = stall_total - base_s;
  endtask

  task automatic drop_start();
    @(posedge clk); #2;
    start_check = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start_check = 1'b0;
    char_mode = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (d_address !== 8'd0) begin n_fail++; $display("FAIL reset_address: got %0d expected 0", d_address); end
    n_checks++; if (d_start !== 1'b0) begin n_fail++; $display("FAIL reset_start_op: got %b expected 0", d_start); end
    n_checks++; if (finish_check !== 1'b0) begin n_fail++; $display("FAIL reset_finish: got %b expected 0", finish_check); end
    n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL reset_key_valid: got %b expected 0", key_valid); end
    n_checks++; if (fail_index !== '0) begin n_fail++; $display("FAIL reset_fail_index: got %0d expected 0", fail_index); end
    n_checks++; if ({d_rw, d_data_out} !== 9'd0) begin n_fail++; $display("FAIL reset_write_port: got rw=%b data=%0d expected 0", d_rw, d_data_out); end
    #1 reset = 1'b0;
  endtask

  // Runs one check with the current memory image and compares it to the model
  task automatic test_scenario(input string name, input int mode, input int fixed_stall);
    bit kv; int fi, k, exp_lat;
    char_mode = mode[1:0];
    model(mode, kv, fi, k);
    run_capture(1'b0);
    exp_lat = (fixed_stall >= 0) ? (3 + fixed_stall) * k : 3 * k + obs_stall;
    n_checks++; if (obs_to) begin n_fail++; $display("FAIL %s_timeout: got no finish expected finish", name); end
    n_checks++; if (key_valid !== kv) begin n_fail++; $display("FAIL %s_key_valid: got %b expected %b", name, key_valid, kv); end
    n_checks++; if (fail_index !== fi[IDX_W-1:0]) begin n_fail++; $display("FAIL %s_fail_index: got %0d expected %0d", name, fail_index, fi); end
    n_checks++; if (obs_lat != exp_lat) begin n_fail++; $display("FAIL %s_latency: got %0d expected %0d", name, obs_lat, exp_lat); end
    n_checks++; if (obs_n != k || !obs_addr_ok) begin n_fail++; $display("FAIL %s_reads: got %0d reads (order ok=%0d) expected %0d in order", name, obs_n, obs_addr_ok, k); end
    n_checks++; if (obs_proto != 0) begin n_fail++; $display("FAIL %s_protocol: got %0d violations expected 0", name, obs_proto); end
    drop_start();
    n_checks++; if (finish_check !== 1'b0) begin n_fail++; $display("FAIL %s_finish_drop: got %b expected 0", name, finish_check); end
  endtask

  task automatic test_all_valid();
    for (int i = 0; i < 256; i++) mem[i] = 8'd97;
    set_memory_timing(1'b1, 0);
    test_scenario("all_valid", 0, 0);
  endtask

  task automatic test_early_fail();
    for (int i = 0; i < 256; i++) mem[i] = 8'd97;
    mem[5] = 8'd210;
    set_memory_timing(1'b1, 0);
    test_scenario("early_fail", 0, 0);
  endtask

  task automatic test_modes();
    for (int i = 0; i < 256; i++) mem[i] = 8'd65;
    set_memory_timing(1'b1, 0);
    test_scenario("upper_mode0", 0, 0);
    test_scenario("upper_mode1", 1, 0);
    test_scenario("upper_mode3", 3, 0);
    test_scenario("upper_mode2", 2, 0);
  endtask

  task automatic test_stall();
    for (int i = 0; i < 256; i++) mem[i] = 8'd97;
    set_memory_timing(1'b0, 1);
    test_scenario("stall2", 0, 2);
    set_memory_timing(1'b1, 0);
  endtask

  task automatic test_reset_midrun();
    int base, n;
    for (int i = 0; i < 256; i++) mem[i] = 8'd97;
    set_memory_timing(1'b1, 0);
    char_mode = 2'd1;
    base = reads.size();
    start_check = 1'b1;
    n = 0;
    while ((reads.size() - base) < 10 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    n_checks++; if ((reads.size() - base) < 10) begin n_fail++; $display("FAIL midrun_progress: got %0d reads expected 10", reads.size() - base); end
    #1 reset = 1'b1;
    @(posedge clk); #1;
    n_checks++; if ({d_start, finish_check, key_valid} !== 3'b000 || d_address !== 8'd0 || fail_index !== '0)
      begin n_fail++; $display("FAIL midrun_reset_values: got start=%b finish=%b kv=%b addr=%0d fi=%0d expected all 0", d_start, finish_check, key_valid, d_address, fail_index); end
    #1 reset = 1'b0;
    run_capture(1'b1);
    n_checks++; if (obs_to || obs_lat != 3 * MSG_LEN) begin n_fail++; $display("FAIL midrun_rerun_latency: got %0d (timeout=%0d) expected %0d", obs_lat, obs_to, 3 * MSG_LEN); end
    n_checks++; if (obs_n != MSG_LEN || !obs_addr_ok) begin n_fail++; $display("FAIL midrun_rerun_reads: got %0d reads (order ok=%0d) expected %0d", obs_n, obs_addr_ok, MSG_LEN); end
    n_checks++; if (key_valid !== 1'b1 || fail_index !== IDX_W'(MSG_LEN)) begin n_fail++; $display("FAIL midrun_rerun_result: got kv=%b fi=%0d expected kv=1 fi=%0d", key_valid, fail_index, MSG_LEN); end
    drop_start();
  endtask

  task automatic test_back_to_back();
    int base;
    bit held;
    for (int i = 0; i < 256; i++) mem[i] = 8'd97;
    mem[20] = 8'd33;
    set_memory_timing(1'b1, 0);
    char_mode = 2'd0;
    run_capture(1'b0);
    base = reads.size();
    held = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
      if (finish_check !== 1'b1) held = 1'b0;
    end
    n_checks++; if (!held) begin n_fail++; $display("FAIL hold_finish: got finish drop expected finish held 1"); end
    n_checks++; if (reads.size() != base) begin n_fail++; $display("FAIL hold_no_reads: got %0d reads expected 0", reads.size() - base); end
    drop_start();
    n_checks++; if (finish_check !== 1'b0) begin n_fail++; $display("FAIL hold_drop: got %b expected 0", finish_check); end
    n_checks++; if (key_valid !== 1'b0 || fail_index !== IDX_W'(20)) begin n_fail++; $display("FAIL idle_retain: got kv=%b fi=%0d expected kv=0 fi=20", key_valid, fail_index); end
    mem[20] = 8'd97;
    run_capture(1'b0);
    n_checks++; if (obs_to || obs_n != MSG_LEN || !obs_addr_ok || key_valid !== 1'b1) begin n_fail++; $display("FAIL restart_run: got %0d reads kv=%b timeout=%0d expected %0d reads kv=1", obs_n, key_valid, obs_to, MSG_LEN); end
    drop_start();
  endtask

  task automatic test_random();
    int kind, mode;
    for (int it = 0; it < 10; it++) begin
      kind = $urandom_range(0, 2);
      mode = $urandom_range(0, 3);
      for (int i = 0; i < MSG_LEN; i++) begin
        if (kind == 0 || $urandom_range(0, 9) < 8)
          mem[i] = ($urandom_range(0, 7) == 0) ? 8'd32 : 8'(97 + $urandom_range(0, 25));
        else
          mem[i] = 8'($urandom_range(0, 255));
      end
      if (it % 3 == 0) set_memory_timing(1'b1, 0);
      else             set_memory_timing(1'b0, 2);
      test_scenario("random", mode, -1);
    end
    set_memory_timing(1'b1, 0);
  endtask

  initial begin
    reset       = 1'b1;
    start_check = 1'b0;
    char_mode   = 2'd0;
    for (int i = 0; i < 256; i++) mem[i] = 8'd0;
    test_reset();
    test_all_valid();
    test_early_fail();
    test_modes();
    test_stall();
    test_reset_midrun();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rc4_plaintext_checker.md
Name: rc4_plaintext_checker

Overview:
Parametrised plaintext validity checker for the RC4 key-search datapath. It runs after each decryption pass. It reads MSG_LEN bytes from decrypted memory through the existing start/finish memory-operation interface and classifies each byte against a runtime-selectable character set. It aborts on the first invalid byte and reports key_Valid plus the failing index to the key-search controller.

Parameters:
MSG_LEN, 32, number of message bytes checked (addresses 0..MSG_LEN-1); legal range 1..2**ADDR_W
ADDR_W, 8, decrypted-memory address width
DATA_W, 8, memory data width; fixed at 8 for ASCII classification
IDX_W, $clog2(MSG_LEN+1), width of fail_index

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
D_data_in  in  DATA_W  byte returned by decrypted memory
D_address  out  ADDR_W  read address
D_data_out  out  DATA_W  write data; tied to 0, block never writes
D_readWrite  out  1  0=read; held 0
D_start_readWrite_op  out  1  one-cycle request pulse to memory interface
D_finish_readWrite_op  in  1  memory interface done; D_data_in valid while high
char_mode  in  2  0=lowercase+space, 1=printable 32..126, 2=alnumeric+space, 3=reserved (treated as 0)
start_check  in  1  four-phase start request
finish_check  out  1  four-phase completion
key_Valid  out  1  1 = all MSG_LEN bytes valid; meaningful while finish_check=1
fail_index  out  IDX_W  address of first invalid byte; MSG_LEN when all valid

Behaviour:
- Reset values: state IDLE, D_address=0, D_start_readWrite_op=0, finish_check=0, key_Valid=0, fail_index=0. D_data_out and D_readWrite are always 0.
- Reset mid-run returns to IDLE next edge with the values above. Any memory op in flight is abandoned, and its late finish is ignored in IDLE.
- FSM states:
  - IDLE: when start_check=1, latch char_mode (3 maps to 0), clear address and index, go to ISSUE.
  - ISSUE: D_start_readWrite_op=1 for exactly this cycle, with D_address=current index. Go to WAIT.
  - WAIT: hold D_address. When D_finish_readWrite_op=1, register D_data_in and go to EVAL; otherwise stay in WAIT, unbounded.
  - EVAL: classify the registered byte.
    - Invalid: key_Valid<=0, fail_index<=index, go to DONE.
    - Valid and index==MSG_LEN-1: key_Valid<=1, fail_index<=MSG_LEN, go to DONE.
    - Otherwise: index++, go to ISSUE.
  - DONE: finish_check=1 with key_Valid and fail_index stable. Stay until start_check=0, then go to IDLE (finish_check=0 from that edge).
- Start held high after DONE does not retrigger; a new run requires start to drop then rise.
- finish_check is never asserted in IDLE.
- Latency with zero-wait memory (D_finish constantly high): 3 cycles per byte checked. finish_check rises 3*K edges after the edge that samples start, where K = bytes read (fail_index+1, or MSG_LEN). Each WAIT stall cycle adds 1.
- D_finish is examined only in WAIT. A level high in ISSUE is not consumed early.
- Character classes, inclusive decimal ranges:
  - mode 0: 97..122 or 32
  - mode 1: 32..126
  - mode 2: 97..122, 65..90, 48..57, or 32
- Index counter is IDX_W wide; no wrap possible since the run terminates at MSG_LEN-1.
- key_Valid and fail_index retain the last result through IDLE until the next EVAL decision.

Decomposition:
- Package rc4_check_pkg:
  - state enum (IDLE, ISSUE, WAIT, EVAL, DONE)
  - char_mode enum
  - ASCII constants: SPACE=32, LC_A=97, LC_Z=122, UC_A=65, UC_Z=90, DIG_0=48, DIG_9=57, PRINT_LO=32, PRINT_HI=126
- Sub-module char_classifier: purely combinational; inputs byte and mode; output valid. Instantiated once, also unit-testable standalone.

Test Plan:
- MSG_LEN=32, mode 0, memory returns 97 ('a') every address, D_finish held 1 -> 32 read pulses at addresses 0..31; finish_check rises 96 clocks after start; key_Valid=1, fail_index=32.
- Mode 0, address 5 returns 210, others 97 -> exactly 6 read pulses (addresses 0..5); key_Valid=0, fail_index=5; finish at 18 clocks.
- Mode 0 vs mode 1, all bytes 65 ('A') -> mode 0: key_Valid=0, fail_index=0; mode 1: key_Valid=1, fail_index=32. Mode 3 behaves identically to mode 0.
- Memory inserts 2 stall cycles per read (D_finish low then high) -> D_address stable during WAIT; D_start pulses exactly one cycle per byte; finish at 5*32=160 clocks; result unchanged.
- Reset asserted at byte 10 of a run, then released with start held 1 -> outputs at reset values; a fresh run starts at address 0 and completes normally.
- Start held 1 after DONE -> finish_check stays 1 and no new reads occur. Drop start -> finish_check falls next edge. Raise start -> new run begins.
